// File: rtl/tblink_rpc_ep_mc_if.sv
// Ring and local-channel handshake bundle for the multi-channel tblink RPC endpoint.
// The slave modport is the endpoint's view; master is the surrounding fabric's view.
interface tblink_rpc_ep_mc_if #(
    parameter int WIDTH = 8,
    parameter int NCHAN = 2
);
    logic [WIDTH-1:0]       neti_dat;
    logic                   neti_valid;
    logic                   neti_ready;
    logic [WIDTH-1:0]       neto_dat;
    logic                   neto_valid;
    logic                   neto_ready;
    logic [NCHAN*WIDTH-1:0] tipi_dat;
    logic [NCHAN-1:0]       tipi_valid;
    logic [NCHAN-1:0]       tipi_ready;
    logic [NCHAN*WIDTH-1:0] tipo_dat;
    logic [NCHAN-1:0]       tipo_valid;
    logic [NCHAN-1:0]       tipo_ready;

    modport slave (
        input  neti_dat, neti_valid, output neti_ready,
        output neto_dat, neto_valid, input  neto_ready,
        input  tipi_dat, tipi_valid, output tipi_ready,
        output tipo_dat, tipo_valid, input  tipo_ready
    );

    modport master (
        output neti_dat, neti_valid, input  neti_ready,
        input  neto_dat, neto_valid, output neto_ready,
        output tipi_dat, tipi_valid, input  tipi_ready,
        input  tipo_dat, tipo_valid, output tipo_ready
    );
endinterface

// File: rtl/tblink_rpc_ep_mc.sv
// Multi-channel tblink ring endpoint: routes ring packets to local channels or a
// pass-through FIFO, and injects FIFO/local packets onto the ring with locked round-robin.
//
// state   | meaning
// P_HDR   | next beat is a header (destination in dat[7:0])
// P_LEN   | next beat is the length N; N=0 ends the packet
// P_BODY  | payload beats; cnt holds beats remaining
// A_IDLE  | no source owns neto; arbitrate this cycle
// A_GRANT | grant_q owns neto until its final beat is accepted
module tblink_rpc_ep_mc #(
    parameter int WIDTH      = 8,
    parameter int NCHAN      = 2,
    parameter int BASE_ADDR  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic uclock,
    input  logic reset,
    input  logic hreq_i,
    output logic hreq_o,
    tblink_rpc_ep_mc_if.slave ep
);
    localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int SW = $clog2(NCHAN + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {P_HDR, P_LEN, P_BODY} pstate_e;
    typedef enum logic {A_IDLE, A_GRANT} astate_e;

    pstate_e        rx_state_q, rx_state_d, tx_state_q, tx_state_d;
    logic [7:0]     rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic           rx_local_q, rx_local_d;
    logic [CW-1:0]  rx_ch_q, rx_ch_d;
    astate_e        arb_q, arb_d;
    logic [SW-1:0]  grant_q, grant_d, last_q, last_d;
    logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic           hreq_q, hreq_d;
    logic [WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];

    logic [7:0]       rx_off;
    logic             rx_local, rx_acc, fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CW-1:0]    rx_ch;
    logic [NCHAN:0]   src_valid;
    logic [SW-1:0]    pick, cur_src;
    logic [SW:0]      idx;
    logic             pick_vld, tx_active, tx_acc, tx_last;
    logic [WIDTH-1:0] tx_dat, fifo_head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];
    assign src_valid  = {!fifo_empty, ep.tipi_valid};
    assign rx_off     = ep.neti_dat[7:0] - 8'(BASE_ADDR);

    // Header beats route from the live destination; later beats follow the latched route.
    always_comb begin
        rx_local = rx_local_q;
        rx_ch    = rx_ch_q;
        if (rx_state_q == P_HDR) begin
            rx_local = (rx_off < 8'(NCHAN));
            rx_ch    = rx_off[CW-1:0];
        end
    end

    always_comb begin
        pick     = last_q;
        pick_vld = 1'b0;
        idx      = '0;
        for (int i = NCHAN + 1; i >= 1; i--) begin
            idx = {1'b0, last_q} + (SW+1)'(i);
            if (idx > (SW+1)'(NCHAN)) idx = idx - (SW+1)'(NCHAN + 1);
            if (src_valid[idx[SW-1:0]]) begin
                pick     = idx[SW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    assign cur_src   = (arb_q == A_GRANT) ? grant_q : pick;
    assign tx_active = (arb_q == A_GRANT) || pick_vld;

    always_comb begin
        tx_dat = fifo_head;
        for (int c = 0; c < NCHAN; c++)
            if (cur_src == SW'(c)) tx_dat = ep.tipi_dat[c*WIDTH +: WIDTH];
    end

    // Outputs are gated by reset so they drop asynchronously even though inputs may be live.
    assign ep.neto_valid = reset && tx_active && src_valid[cur_src];
    assign ep.neto_dat   = ep.neto_valid ? tx_dat : '0;
    assign tx_acc        = ep.neto_valid && ep.neto_ready;
    assign fifo_pop      = tx_acc && (cur_src == SW'(NCHAN));
    assign ep.neti_ready = reset && (rx_local ? ep.tipo_ready[rx_ch] : (!fifo_full || fifo_pop));
    assign rx_acc        = ep.neti_valid && ep.neti_ready;
    assign fifo_push     = rx_acc && !rx_local;
    assign hreq_o        = hreq_q;

    always_comb begin
        ep.tipi_ready = '0;
        ep.tipo_valid = '0;
        ep.tipo_dat   = '0;
        for (int c = 0; c < NCHAN; c++) begin
            ep.tipi_ready[c] = reset && tx_active && (cur_src == SW'(c)) && ep.neto_ready;
            ep.tipo_valid[c] = reset && ep.neti_valid && rx_local && (rx_ch == CW'(c));
            if (ep.tipo_valid[c]) ep.tipo_dat[c*WIDTH +: WIDTH] = ep.neti_dat;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_local_d = rx_local_q;
        rx_ch_d    = rx_ch_q;
        if (rx_acc) begin
            case (rx_state_q)
                P_HDR: begin
                    rx_state_d = P_LEN;
                    rx_local_d = rx_local;
                    rx_ch_d    = rx_ch;
                end
                P_LEN: begin
                    rx_cnt_d   = ep.neti_dat[7:0];
                    rx_state_d = (ep.neti_dat[7:0] == 8'd0) ? P_HDR : P_BODY;
                end
                default: begin
                    rx_cnt_d   = rx_cnt_q - 8'd1;
                    rx_state_d = (rx_cnt_q == 8'd1) ? P_HDR : P_BODY;
                end
            endcase
        end
    end

    assign tx_last = tx_acc && (((tx_state_q == P_LEN) && (tx_dat[7:0] == 8'd0)) ||
                                ((tx_state_q == P_BODY) && (tx_cnt_q == 8'd1)));

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        if (tx_acc) begin
            case (tx_state_q)
                P_HDR:   tx_state_d = P_LEN;
                P_LEN: begin
                    tx_cnt_d   = tx_dat[7:0];
                    tx_state_d = (tx_dat[7:0] == 8'd0) ? P_HDR : P_BODY;
                end
                default: begin
                    tx_cnt_d   = tx_cnt_q - 8'd1;
                    tx_state_d = (tx_cnt_q == 8'd1) ? P_HDR : P_BODY;
                end
            endcase
        end
    end

    // The grant is taken as soon as a beat is presented so neto stays stable while stalled.
    always_comb begin
        arb_d   = arb_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (arb_q == A_IDLE) begin
            if (pick_vld) begin
                arb_d   = A_GRANT;
                grant_d = pick;
                last_d  = pick;
            end
        end else if (tx_last) begin
            arb_d = A_IDLE;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + (fifo_push ? (AW+1)'(1) : '0);
        rd_ptr_d = rd_ptr_q + (fifo_pop  ? (AW+1)'(1) : '0);
        hreq_d   = hreq_i | (|ep.tipi_valid);
    end

    always_ff @(posedge uclock) begin
        if (fifo_push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= ep.neti_dat;
    end

    always_ff @(posedge uclock or negedge reset) begin
        if (!reset) begin
            rx_state_q <= P_HDR;
            rx_cnt_q   <= '0;
            rx_local_q <= 1'b0;
            rx_ch_q    <= '0;
            tx_state_q <= P_HDR;
            tx_cnt_q   <= '0;
            arb_q      <= A_IDLE;
            grant_q    <= '0;
            last_q     <= SW'(NCHAN);
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            hreq_q     <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_local_q <= rx_local_d;
            rx_ch_q    <= rx_ch_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            arb_q      <= arb_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            hreq_q     <= hreq_d;
        end
    end
endmodule

// File: tb/tb_tblink_rpc_ep_mc.sv
// Bench for tblink_rpc_ep_mc: directed scenarios plus randomized traffic checked against
// a packet-level model (per-source expected beat queues, whole-packet matching on neto).
module tb_tblink_rpc_ep_mc;
    localparam int W    = 8;
    localparam int NC   = 2;
    localparam int BASE = 1;
    localparam int TMO  = 5000;

    typedef logic [7:0] beat_q_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hreq_i = 1'b0;
    logic hreq_o;
    always #5 clk = ~clk;

    tblink_rpc_ep_mc_if #(.WIDTH(W), .NCHAN(NC)) bus ();

    tblink_rpc_ep_mc #(.WIDTH(W), .NCHAN(NC), .BASE_ADDR(BASE), .FIFO_DEPTH(4)) dut (
        .uclock (clk),
        .reset  (rst_n),
        .hreq_i (hreq_i),
        .hreq_o (hreq_o),
        .ep     (bus)
    );

    logic [7:0]  neti_dat_r = '0;
    logic        neti_valid_r = 1'b0;
    logic [7:0]  tipi_dat_r [NC];
    logic        tipi_valid_r [NC];
    int          neto_mode = 1;
    int          tipo_mode = 1;
    logic [31:0] rnd = '0;

    assign bus.neti_dat   = neti_dat_r;
    assign bus.neti_valid = neti_valid_r;
    assign bus.neto_ready = (neto_mode == 2) ? rnd[0] : (neto_mode == 1);
    assign bus.tipo_ready = (tipo_mode == 2) ? rnd[NC:1] : {NC{tipo_mode == 1}};
    always_comb begin
        for (int c = 0; c < NC; c++) begin
            bus.tipi_dat[c*W +: W] = tipi_dat_r[c];
            bus.tipi_valid[c]      = tipi_valid_r[c];
        end
    end

    always begin
        @(posedge clk);
        #1 rnd = $urandom;
    end

    int n_chk = 0, n_fail = 0, cyc = 0;
    int neti_acc = 0, neto_cnt = 0;
    int tipo_cnt [NC];
    beat_q_t exp_neto [NC+1];
    beat_q_t exp_tipo [NC];
    beat_q_t cur_pkt;
    int src_log[$];
    int acc_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic match_pkt();
        int hit;
        int len;
        bit ok;
        hit = -1;
        len = cur_pkt.size();
        for (int s = 0; s <= NC; s++) begin
            if (hit < 0 && exp_neto[s].size() >= len) begin
                ok = 1'b1;
                for (int i = 0; i < len; i++)
                    if (exp_neto[s][i] !== cur_pkt[i]) ok = 1'b0;
                if (ok) hit = s;
            end
        end
        check_eq("neto_pkt_match", 32'(hit >= 0), 1);
        if (hit >= 0) begin
            src_log.push_back(hit);
            for (int i = 0; i < len; i++) void'(exp_neto[hit].pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            cur_pkt.delete();
        end else begin
            if (bus.neti_valid && bus.neti_ready) neti_acc++;
            for (int c = 0; c < NC; c++) begin
                if (bus.tipo_valid[c] && bus.tipo_ready[c]) begin
                    tipo_cnt[c]++;
                    if (exp_tipo[c].size() == 0) check_eq("tipo_unexpected_beat", 1, 0);
                    else check_eq($sformatf("tipo%0d_beat", c), 32'(bus.tipo_dat[c*W +: W]),
                                  32'(exp_tipo[c].pop_front()));
                end
            end
            if (bus.neto_valid && bus.neto_ready) begin
                neto_cnt++;
                acc_cyc.push_back(cyc);
                cur_pkt.push_back(bus.neto_dat);
                if (cur_pkt.size() >= 2 && cur_pkt.size() == int'(cur_pkt[1]) + 2) begin
                    match_pkt();
                    cur_pkt.delete();
                end
            end
        end
    end

    function automatic beat_q_t mk_pkt(input logic [7:0] dst, input int n);
        beat_q_t p;
        p.push_back(dst);
        p.push_back(8'(n));
        for (int i = 0; i < n; i++) p.push_back(8'($urandom));
        return p;
    endfunction

    function automatic logic [7:0] rand_dst();
        case ($urandom_range(0, 4))
            0:       return 8'(BASE);
            1:       return 8'(BASE + 1);
            2:       return 8'd7;
            3:       return 8'd0;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic int pending();
        int s;
        s = 0;
        for (int i = 0; i <= NC; i++) s += exp_neto[i].size();
        for (int i = 0; i < NC; i++) s += exp_tipo[i].size();
        return s;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic neti_beat(input logic [7:0] d);
        int t;
        bit acc;
        t = 0;
        acc = 1'b0;
        neti_dat_r = d;
        neti_valid_r = 1'b1;
        while (!acc && t < TMO) begin
            @(negedge clk);
            acc = bus.neti_ready;
            @(posedge clk);
            #1 t++;
        end
        if (!acc) check_eq("neti_accept_timeout", 0, 1);
    endtask

    task automatic drive_neti(input beat_q_t p);
        logic [7:0] off;
        off = p[0] - 8'(BASE);
        for (int i = 0; i < p.size(); i++) begin
            if (off < 8'(NC)) exp_tipo[off].push_back(p[i]);
            else exp_neto[NC].push_back(p[i]);
        end
        for (int i = 0; i < p.size(); i++) neti_beat(p[i]);
        neti_valid_r = 1'b0;
    endtask

    task automatic drive_tipi(input int c, input beat_q_t p);
        int t;
        bit acc;
        for (int i = 0; i < p.size(); i++) exp_neto[c].push_back(p[i]);
        for (int i = 0; i < p.size(); i++) begin
            tipi_dat_r[c] = p[i];
            tipi_valid_r[c] = 1'b1;
            t = 0;
            acc = 1'b0;
            while (!acc && t < TMO) begin
                @(negedge clk);
                acc = bus.tipi_ready[c];
                @(posedge clk);
                #1 t++;
            end
            if (!acc) check_eq("tipi_accept_timeout", 0, 1);
        end
        tipi_valid_r[c] = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((pending() != 0 || cur_pkt.size() != 0) && t < TMO) begin
            @(posedge clk);
            t++;
        end
        check_eq("drain_pending_beats", 32'(pending()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, c0, c1, t0;
        beat_q_t p;
        for (int c = 0; c < NC; c++) begin
            tipi_dat_r[c] = '0;
            tipi_valid_r[c] = 1'b0;
            tipo_cnt[c] = 0;
        end
        hreq_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_neto_valid", 32'(bus.neto_valid), 0);
        check_eq("rst_neti_ready", 32'(bus.neti_ready), 0);
        check_eq("rst_tipi_ready", 32'(bus.tipi_ready), 0);
        check_eq("rst_tipo_valid", 32'(bus.tipo_valid), 0);
        check_eq("rst_hreq_o", 32'(hreq_o), 0);
        hreq_i = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;

        // local delivery to channel 1
        sync();
        c0 = tipo_cnt[0]; c1 = tipo_cnt[1]; n0 = neto_cnt;
        p = '{8'(BASE + 1), 8'd3, 8'hA1, 8'hA2, 8'hA3};
        drive_neti(p);
        repeat (3) @(posedge clk);
        check_eq("local_tipo1_beats", 32'(tipo_cnt[1] - c1), 5);
        check_eq("local_tipo0_beats", 32'(tipo_cnt[0] - c0), 0);
        check_eq("local_neto_beats", 32'(neto_cnt - n0), 0);

        // pass-through with neto stalled
        sync();
        neto_mode = 0;
        n0 = neti_acc;
        fork
            drive_neti(mk_pkt(8'd7, 5));
            begin
                repeat (12) @(posedge clk);
                #2;
                check_eq("pt_beats_before_full", 32'(neti_acc - n0), 4);
                check_eq("pt_neti_ready_full", 32'(bus.neti_ready), 0);
                check_eq("pt_neto_valid_stalled", 32'(bus.neto_valid), 1);
                neto_mode = 1;
            end
        join
        wait_drain();

        // round-robin: ch0, ch1, then fifo
        sync();
        neto_mode = 0;
        src_log.delete();
        fork
            drive_tipi(0, mk_pkt(8'h30, 2));
            drive_tipi(1, mk_pkt(8'h31, 2));
            drive_neti(mk_pkt(8'd7, 1));
            begin
                repeat (10) @(posedge clk);
                #2 neto_mode = 1;
            end
        join
        wait_drain();
        check_eq("rr_pkt_count", 32'(src_log.size()), 3);
        if (src_log.size() == 3) begin
            check_eq("rr_first_src", 32'(src_log[0]), 0);
            check_eq("rr_second_src", 32'(src_log[1]), 1);
            check_eq("rr_third_src", 32'(src_log[2]), NC);
        end

        // zero-length back-to-back
        sync();
        acc_cyc.delete();
        drive_tipi(0, mk_pkt(8'h40, 0));
        drive_tipi(0, mk_pkt(8'h41, 0));
        repeat (3) @(posedge clk);
        check_eq("zl_beat_count", 32'(acc_cyc.size()), 4);
        if (acc_cyc.size() == 4) check_eq("zl_no_bubble", 32'(acc_cyc[3] - acc_cyc[0]), 3);

        // host request chain
        sync();
        hreq_i = 1'b1;
        @(negedge clk);
        check_eq("hreq_not_yet", 32'(hreq_o), 0);
        @(posedge clk);
        #1 hreq_i = 1'b0;
        @(negedge clk);
        check_eq("hreq_one_cycle_later", 32'(hreq_o), 1);
        @(negedge clk);
        check_eq("hreq_pulse_end", 32'(hreq_o), 0);
        sync();
        neto_mode = 0;
        fork
            drive_tipi(1, mk_pkt(8'h50, 1));
            begin
                @(negedge clk);
                check_eq("hreq_tipi_lag", 32'(hreq_o), 0);
                repeat (4) begin
                    @(negedge clk);
                    check_eq("hreq_tipi_hold", 32'(hreq_o), 1);
                end
                @(posedge clk);
                #2 neto_mode = 1;
            end
        join
        wait_drain();

        // reset mid-packet
        sync();
        neto_mode = 0;
        hreq_i = 1'b1;
        neti_beat(8'd7);
        neti_beat(8'd8);
        neti_dat_r = 8'h77;
        neti_valid_r = 1'b1;
        @(negedge clk);
        check_eq("pre_rst_neto_valid", 32'(bus.neto_valid), 1);
        check_eq("pre_rst_hreq_o", 32'(hreq_o), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_neto_valid", 32'(bus.neto_valid), 0);
        check_eq("async_rst_neti_ready", 32'(bus.neti_ready), 0);
        check_eq("async_rst_tipo_valid", 32'(bus.tipo_valid), 0);
        check_eq("async_rst_tipi_ready", 32'(bus.tipi_ready), 0);
        check_eq("async_rst_hreq_o", 32'(hreq_o), 0);
        neti_valid_r = 1'b0;
        hreq_i = 1'b0;
        neto_mode = 1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        sync();
        n0 = neto_cnt;
        drive_neti(mk_pkt(8'd7, 0));
        wait_drain();
        repeat (6) @(posedge clk);
        check_eq("post_rst_neto_beats", 32'(neto_cnt - n0), 2);
        check_eq("post_rst_residual", 32'(cur_pkt.size()), 0);

        // randomized mixed traffic
        sync();
        neto_mode = 2;
        tipo_mode = 2;
        fork
            for (int i = 0; i < 10; i++) drive_neti(mk_pkt(rand_dst(), $urandom_range(0, 6)));
            for (int i = 0; i < 6; i++)
                drive_tipi(0, mk_pkt(rand_dst(), (i == 3) ? 255 : $urandom_range(0, 6)));
            for (int i = 0; i < 6; i++) drive_tipi(1, mk_pkt(rand_dst(), $urandom_range(0, 6)));
        join
        neto_mode = 1;
        tipo_mode = 1;
        wait_drain();
        t0 = 0;
        repeat (5) @(posedge clk);
        check_eq("final_pending", 32'(pending()), 0);
        check_eq("final_partial_pkt", 32'(cur_pkt.size() + t0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tblink_rpc_ep_mc.md
# tblink_rpc_ep_mc

Multi-channel, width-parametrised ring endpoint for the tblink RPC network, the successor to the single-address 8-bit endpoint. It sits on the `neti`/`neto` ring between the RPC controller and other endpoints and owns `NCHAN` consecutive ring addresses. Packets addressed to it are routed to per-channel `tipo` ports; packets on `tipi` ports are injected onto the ring. Through-traffic passes via an internal FIFO. Injection uses round-robin arbitration that is locked for the whole packet, and the endpoint drives a registered host-request chain.

## Interface
- `WIDTH`, 8: beat width in bits; must be ≥ 8.
- `NCHAN`, 2: local channel count, 1..8.
- `BASE_ADDR`, 1: address of channel 0. Channel c owns `BASE_ADDR+c`. Address 0 is the controller and must not be owned.
- `FIFO_DEPTH`, 4: pass-through FIFO depth; must be a power of 2 and ≥ 2.
- `uclock`  in  1  sole clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `hreq_i`  in  1  host request from the upstream endpoint.
- `hreq_o`  out  1  host request to the downstream endpoint or controller.
- `neti_dat`/`neti_valid`/`neti_ready`  in/in/out  WIDTH/1/1  ring input.
- `neto_dat`/`neto_valid`/`neto_ready`  out/out/in  WIDTH/1/1  ring output.
- `tipi_dat`/`tipi_valid`/`tipi_ready`  in/in/out  NCHAN*WIDTH/NCHAN/NCHAN  local injection channels; channel c occupies `[c*WIDTH +: WIDTH]`.
- `tipo_dat`/`tipo_valid`/`tipo_ready`  out/out/in  NCHAN*WIDTH/NCHAN/NCHAN  local delivery channels, packed the same way.

## Operation
- **Packet format:**
  - Beat 0 is the header; `dat[7:0]` is the destination address and the upper bits are opaque.
  - Beat 1 is the length N, taken from `dat[7:0]`, range 0..255.
  - N payload beats follow, so the total is N+2 beats.
- **Beat transfer:** a beat moves when `valid && ready`. Senders hold `dat` and `valid` stable until the beat is accepted.
- **Rx parser states** (on `neti`): HDR → LEN → BODY → HDR.
  - In LEN, N=0 returns directly to HDR.
  - In BODY, a counter decrements on each beat. When the counter is 1 and a beat is accepted, the parser returns to HDR.
- **Route decision** is made on the header beat and latched for the whole packet:
  - If `dst-BASE_ADDR < NCHAN` (unsigned 8-bit), the packet goes to local channel `dst-BASE_ADDR`. All beats, including header and length, are forwarded unmodified to that `tipo`.
  - Otherwise the packet is pass-through and its beats are written into the FIFO.
- **Rx backpressure:**
  - `neti_ready` equals the selected sink's readiness: `tipo_ready[c]` for a local packet, or FIFO not full for pass-through.
  - In HDR, `neti_ready` is computed from the route the incoming header selects.
- **Tx arbiter states:** IDLE → GRANT(src) → IDLE.
  - Sources are the FIFO head (index NCHAN) and each `tipi[c]`.
  - In IDLE, the arbiter picks among sources presenting valid using round-robin starting after the last winner. After reset the last winner is NCHAN, so channel 0 has first priority.
  - The grant locks until that source's final beat is accepted on `neto`. A parser identical to the Rx parser tracks beat count.
  - Only the granted source sees `ready = neto_ready`; all other `tipi_ready` are 0.
  - The arbiter enters GRANT and presents the first beat in the same cycle as IDLE sees a valid source. There is no bubble between packets: the arbiter can re-arbitrate on the cycle the last beat is accepted.
- **Local loopback:** a `tipi` packet whose destination is one of this block's own addresses is still sent on `neto`. There is no local loopback.
- **Host request:** `hreq_o <= hreq_i | (|tipi_valid)`, registered.
- **Reset (`reset`=0, asynchronous):**
  - Outputs: all `valid` and `ready` signals and `hreq_o` go to 0; `neto_dat` and `tipo_dat` go to 0.
  - State: the FIFO is emptied, parsers return to HDR, the arbiter returns to IDLE, and the last winner is set to NCHAN.
  - Partially transferred packets are discarded; no recovery is attempted.

## Timing
- Local delivery is combinational from `neti` to `tipo`, with 0-cycle latency.
- Pass-through latency is 1 cycle: a beat written at edge k is visible on `neto` after edge k. The FIFO supports a simultaneous push and pop when full; the pop frees a slot for the same-edge push.
- FIFO full: `neti_ready`=0 for pass-through beats. FIFO empty: the FIFO source is not valid.
- `tipi` to `neto` is combinational while granted.
- `hreq_o` lags its inputs by 1 cycle.
- Length counter width is 8 bits; N=255 yields 257 beats with no wrap error.

## Test plan
- **Local delivery:** reset, then a `neti` packet with dst=`BASE_ADDR+1`, N=3, payload 0xA1,0xA2,0xA3 → exactly 5 beats on `tipo[1]` in order, nothing on `neto` or `tipo[0]`.
- **Pass-through with backpressure:** `neti` packet with dst=7, N=5, while `neto_ready`=0 → FIFO fills and `neti_ready` drops after 4 beats. Then `neto_ready`=1 → all 7 beats appear on `neto` in order, intact.
- **Round-robin fairness:** `tipi[0]`, `tipi[1]` and a pass-through packet all valid simultaneously → `neto` order is ch0, ch1, FIFO, with no beat interleaving between packets.
- **Zero-length and back-to-back:** N=0 packets sent back-to-back on `tipi[0]` → 2 beats each with no idle cycle between them when `neto_ready`=1 throughout.
- **Host request chain:** `hreq_i`=1 for one cycle → `hreq_o`=1 exactly one cycle later. Hold `tipi_valid[1]`=1 → `hreq_o`=1 one cycle later and remains 1 while the valid is held.
- **Reset mid-packet:** assert `reset` during beat 2 of a 10-beat pass-through → asynchronously all valid signals=0 and `hreq_o`=0. After release, a fresh 2-beat packet passes correctly with no residual beats.
